// File: rtl/pause_ctrl.sv
// Pipeline pause/flush controller: memory-wait stalls, branch flushes and load-use bubbles.
// Optional memory-wait abort counter enabled by defining PAUSE_CTRL_TIMEOUT_EN.
module pause_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [3:0]  IdRs1Idx,
    input  logic [3:0]  IdRs2Idx,
    input  logic        IdUseRs1,
    input  logic        IdUseRs2,
    input  logic        ExMemRead,
    input  logic [3:0]  ExWriteIdx,
    input  logic        BranchTaken,
    input  logic        MemReq,
    input  logic        MemAck,
    output logic        PauseIf,
    output logic        PauseId,
    output logic        PauseEx,
    output logic        FlushId,
    output logic        BubbleEx,
    output logic        MemTimeout,
    output logic [15:0] StallCount
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t state, state_nxt;
    logic   pend_flush, pend_flush_nxt;
    logic   load_use;
    logic   mem_done;
    logic   timeout;
    logic   pause_if, pause_id, pause_ex, flush_id, bubble_ex;

    assign load_use = ExMemRead &
                      ((IdUseRs1 & (IdRs1Idx == ExWriteIdx)) |
                       (IdUseRs2 & (IdRs2Idx == ExWriteIdx)));

`ifdef PAUSE_CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Timeout fires in the wait cycle that would bring the count up to TIMEOUT_CYCLES.
    assign timeout = (state == MEM_WAIT) && !MemAck &&
                     (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wait_cnt <= 8'd0;
        end else if (state == RUN) begin
            wait_cnt <= 8'd0;
        end else if (!MemAck) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    assign mem_done = MemAck | timeout;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= RUN;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            pend_flush <= pend_flush_nxt;
        end
    end

    // Priority in both states: memory stall, then flush, then load-use bubble.
    always_comb begin
        state_nxt      = state;
        pend_flush_nxt = pend_flush;
        pause_if       = 1'b0;
        pause_id       = 1'b0;
        pause_ex       = 1'b0;
        flush_id       = 1'b0;
        bubble_ex      = 1'b0;
        case (state)
            RUN: begin
                if (MemReq && !MemAck) begin
                    pause_if       = 1'b1;
                    pause_id       = 1'b1;
                    pause_ex       = 1'b1;
                    state_nxt      = MEM_WAIT;
                    pend_flush_nxt = BranchTaken;
                end else if (BranchTaken) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end else if (load_use) begin
                    pause_if  = 1'b1;
                    pause_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_done) begin
                    state_nxt      = RUN;
                    pend_flush_nxt = 1'b0;
                    // A branch seen on the release cycle is folded in like a pending one.
                    if (pend_flush || BranchTaken) begin
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (load_use) begin
                        pause_if  = 1'b1;
                        pause_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end else begin
                    pause_if       = 1'b1;
                    pause_id       = 1'b1;
                    pause_ex       = 1'b1;
                    pend_flush_nxt = pend_flush | BranchTaken;
                end
            end
            default: begin
                state_nxt      = RUN;
                pend_flush_nxt = 1'b0;
            end
        endcase
    end

    // Gating with Rst releases every pause immediately when reset asserts mid-wait.
    assign PauseIf    = Rst & pause_if;
    assign PauseId    = Rst & pause_id;
    assign PauseEx    = Rst & pause_ex;
    assign FlushId    = Rst & flush_id;
    assign BubbleEx   = Rst & bubble_ex;
    assign MemTimeout = Rst & timeout;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            StallCount <= 16'd0;
        end else if (PauseIf && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_pause_ctrl.sv
// Directed testbench for pause_ctrl; each task drives one scenario and checks inline.
// Define PAUSE_CTRL_TIMEOUT_EN to exercise the memory-wait abort with TIMEOUT_CYCLES=8.
module tb_pause_ctrl;

`ifdef PAUSE_CTRL_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        Clk;
    logic        Rst;
    logic [3:0]  IdRs1Idx;
    logic [3:0]  IdRs2Idx;
    logic        IdUseRs1;
    logic        IdUseRs2;
    logic        ExMemRead;
    logic [3:0]  ExWriteIdx;
    logic        BranchTaken;
    logic        MemReq;
    logic        MemAck;
    logic        PauseIf;
    logic        PauseId;
    logic        PauseEx;
    logic        FlushId;
    logic        BubbleEx;
    logic        MemTimeout;
    logic [15:0] StallCount;

    int checks = 0;
    int errors = 0;

    // Output bundle order: PauseIf PauseId PauseEx FlushId BubbleEx MemTimeout
    logic [5:0] outs;
    assign outs = {PauseIf, PauseId, PauseEx, FlushId, BubbleEx, MemTimeout};

    pause_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .IdRs1Idx   (IdRs1Idx),
        .IdRs2Idx   (IdRs2Idx),
        .IdUseRs1   (IdUseRs1),
        .IdUseRs2   (IdUseRs2),
        .ExMemRead  (ExMemRead),
        .ExWriteIdx (ExWriteIdx),
        .BranchTaken(BranchTaken),
        .MemReq     (MemReq),
        .MemAck     (MemAck),
        .PauseIf    (PauseIf),
        .PauseId    (PauseId),
        .PauseEx    (PauseEx),
        .FlushId    (FlushId),
        .BubbleEx   (BubbleEx),
        .MemTimeout (MemTimeout),
        .StallCount (StallCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic set_idle();
        IdRs1Idx    = 4'd0;
        IdRs2Idx    = 4'd0;
        IdUseRs1    = 1'b0;
        IdUseRs2    = 1'b0;
        ExMemRead   = 1'b0;
        ExWriteIdx  = 4'd0;
        BranchTaken = 1'b0;
        MemReq      = 1'b0;
        MemAck      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        set_idle();
        Rst = 1'b0;
        #2;
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        // Outputs must stay 0 during reset even with a load-use pattern applied.
        Rst        = 1'b0;
        set_idle();
        ExMemRead  = 1'b1;
        ExWriteIdx = 4'd3;
        IdUseRs1   = 1'b1;
        IdRs1Idx   = 4'd3;
        #2;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL reset_outs: got %b expected %b", outs, 6'b000000);
        end
        checks++;
        if (StallCount !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected %0d", StallCount, 0);
        end
        @(negedge Clk);
        set_idle();
        Rst = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge Clk);
        ExMemRead  = 1'b1;
        ExWriteIdx = 4'd3;
        IdUseRs1   = 1'b1;
        IdRs1Idx   = 4'd3;
        #1;
        checks++;
        if (outs !== 6'b110010) begin
            errors++;
            $display("[TB] FAIL lu_rs1: got %b expected %b", outs, 6'b110010);
        end
        @(negedge Clk);
        ExMemRead = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL lu_cleared: got %b expected %b", outs, 6'b000000);
        end
        checks++;
        if (StallCount !== 16'd1) begin
            errors++;
            $display("[TB] FAIL lu_count: got %0d expected %0d", StallCount, 1);
        end
        @(negedge Clk);
        ExMemRead  = 1'b1;
        ExWriteIdx = 4'd5;
        IdUseRs2   = 1'b1;
        IdRs2Idx   = 4'd5;
        #1;
        checks++;
        if (outs !== 6'b110010) begin
            errors++;
            $display("[TB] FAIL lu_rs2: got %b expected %b", outs, 6'b110010);
        end
        @(negedge Clk);
        IdUseRs2 = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL lu_unused_rs2: got %b expected %b", outs, 6'b000000);
        end
        checks++;
        if (StallCount !== 16'd2) begin
            errors++;
            $display("[TB] FAIL lu_count2: got %0d expected %0d", StallCount, 2);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        @(negedge Clk);
        MemReq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (outs !== 6'b111000) begin
                errors++;
                $display("[TB] FAIL mem_wait_cycle%0d: got %b expected %b", i, outs, 6'b111000);
            end
            @(negedge Clk);
        end
        MemAck = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL mem_ack: got %b expected %b", outs, 6'b000000);
        end
        @(negedge Clk);
        set_idle();
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL mem_after: got %b expected %b", outs, 6'b000000);
        end
        checks++;
        if (StallCount !== 16'd5) begin
            errors++;
            $display("[TB] FAIL mem_count: got %0d expected %0d", StallCount, 5);
        end
    endtask

    task automatic test_branch_in_wait();
        do_reset();
        @(negedge Clk);
        MemReq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            BranchTaken = (i == 2);
            #1;
            checks++;
            if (outs !== 6'b111000) begin
                errors++;
                $display("[TB] FAIL br_wait_cycle%0d: got %b expected %b", i, outs, 6'b111000);
            end
            @(negedge Clk);
        end
        BranchTaken = 1'b0;
        MemAck      = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b000110) begin
            errors++;
            $display("[TB] FAIL br_flush_on_ack: got %b expected %b", outs, 6'b000110);
        end
        @(negedge Clk);
        set_idle();
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL br_flush_once: got %b expected %b", outs, 6'b000000);
        end
    endtask

    task automatic test_priority();
        do_reset();
        @(negedge Clk);
        ExMemRead   = 1'b1;
        ExWriteIdx  = 4'd7;
        IdUseRs1    = 1'b1;
        IdRs1Idx    = 4'd7;
        BranchTaken = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b000110) begin
            errors++;
            $display("[TB] FAIL prio_branch_over_lu: got %b expected %b", outs, 6'b000110);
        end
        @(negedge Clk);
        BranchTaken = 1'b0;
        MemReq      = 1'b1;
        MemAck      = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b110010) begin
            errors++;
            $display("[TB] FAIL prio_same_cycle_ack: got %b expected %b", outs, 6'b110010);
        end
        @(negedge Clk);
        ExMemRead   = 1'b0;
        MemAck      = 1'b0;
        BranchTaken = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b111000) begin
            errors++;
            $display("[TB] FAIL prio_mem_over_branch: got %b expected %b", outs, 6'b111000);
        end
        @(negedge Clk);
        BranchTaken = 1'b0;
        MemAck      = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b000110) begin
            errors++;
            $display("[TB] FAIL prio_pending_flush: got %b expected %b", outs, 6'b000110);
        end
        @(negedge Clk);
        set_idle();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        @(negedge Clk);
        MemReq = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        checks++;
        if (outs !== 6'b111000) begin
            errors++;
            $display("[TB] FAIL rst_pre_wait: got %b expected %b", outs, 6'b111000);
        end
        #1;
        Rst = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL rst_async_outs: got %b expected %b", outs, 6'b000000);
        end
        checks++;
        if (StallCount !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rst_async_count: got %0d expected %0d", StallCount, 0);
        end
        @(negedge Clk);
        Rst    = 1'b1;
        MemReq = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL rst_back_to_run: got %b expected %b", outs, 6'b000000);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge Clk);
        MemReq = 1'b1;
`ifdef PAUSE_CTRL_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (outs !== 6'b111000) begin
                errors++;
                $display("[TB] FAIL to_wait_cycle%0d: got %b expected %b", i, outs, 6'b111000);
            end
            @(negedge Clk);
        end
        #1;
        checks++;
        if (outs !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL to_pulse: got %b expected %b", outs, 6'b000001);
        end
        @(negedge Clk);
        MemReq = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL to_after: got %b expected %b", outs, 6'b000000);
        end
`else
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (outs !== 6'b111000) begin
                errors++;
                $display("[TB] FAIL to_unbounded%0d: got %b expected %b", i, outs, 6'b111000);
            end
            @(negedge Clk);
        end
        MemAck = 1'b1;
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL to_unbounded_ack: got %b expected %b", outs, 6'b000000);
        end
        @(negedge Clk);
        set_idle();
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch_in_wait();
        test_priority();
        test_reset_mid_wait();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pause_ctrl.md
PAUSE_CTRL -- requirements
Module: pause_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, memory-wait cycles before abort; 8-bit range 1..255.
REQ-002 Clk  in  1  clock; all state updates on posedge.
REQ-003 Rst  in  1  reset, asynchronous, active-low.
REQ-004 IdRs1Idx  in  4  first source register index of the instruction in ID.
REQ-005 IdRs2Idx  in  4  second source register index of the instruction in ID.
REQ-006 IdUseRs1  in  1  ID instruction reads IdRs1Idx.
REQ-007 IdUseRs2  in  1  ID instruction reads IdRs2Idx.
REQ-008 ExMemRead  in  1  instruction held in ID/EX is a load.
REQ-009 ExWriteIdx  in  4  destination register index held in ID/EX.
REQ-010 BranchTaken  in  1  EX resolved a taken branch or jump this cycle.
REQ-011 MemReq  in  1  MEM stage issues a RAM read or write this cycle.
REQ-012 MemAck  in  1  RAM completes the outstanding access this cycle.
REQ-013 PauseIf  out  1  hold PC and IF/ID register.
REQ-014 PauseId  out  1  hold ID/EX register (drives its Pause input).
REQ-015 PauseEx  out  1  hold EX/MEM register.
REQ-016 FlushId  out  1  replace IF/ID contents with a no-op.
REQ-017 BubbleEx  out  1  force ID/EX controls to no-op (writes/memory off, no_alu_op, NB).
REQ-018 MemTimeout  out  1  one-cycle pulse on memory-wait abort.
REQ-019 StallCount  out  16  count of cycles with PauseIf=1.

Function
REQ-020 States: RUN, MEM_WAIT; register PendFlush (1 bit); outputs combinational from state, PendFlush and inputs.
REQ-021 Load-use hazard LU = ExMemRead & ((IdUseRs1 & IdRs1Idx==ExWriteIdx) | (IdUseRs2 & IdRs2Idx==ExWriteIdx)).
REQ-022 RUN, MemReq & !MemAck: PauseIf=PauseId=PauseEx=1, no flush/bubble; next state MEM_WAIT; PendFlush <= BranchTaken.
REQ-023 RUN, MemReq & MemAck same cycle: no pause from memory; stay RUN.
REQ-024 RUN, BranchTaken (memory not stalling): FlushId=BubbleEx=1, pauses 0; LU ignored that cycle.
REQ-025 RUN, LU & !BranchTaken (memory not stalling): PauseIf=PauseId=1, BubbleEx=1, PauseEx=0; exactly one cycle per load since bubble clears LU.
REQ-026 MEM_WAIT: PauseIf=PauseId=PauseEx=1 every cycle MemAck=0; BranchTaken here ORs into PendFlush.
REQ-027 MEM_WAIT with MemAck: pauses 0; if PendFlush, FlushId=BubbleEx=1 that cycle; else LU rule applies; next RUN, PendFlush <= 0.
REQ-028 Priority: memory stall > flush > load-use.
REQ-029 StallCount increments on every posedge where PauseIf=1; saturates at 16'hFFFF, no wrap.
REQ-030 MemTimeout = 0 except as given in REQ-034.

Reset
REQ-031 Rst low: state RUN, PendFlush 0, StallCount 0, wait counter 0, immediately and independent of Clk.
REQ-032 During reset all outputs 0; reset mid-MEM_WAIT releases all pauses in the same cycle.

Configuration
REQ-033 Macro PAUSE_CTRL_TIMEOUT_EN enables an 8-bit wait counter, cleared on MEM_WAIT entry, incremented each MEM_WAIT cycle without MemAck.
REQ-034 With PAUSE_CTRL_TIMEOUT_EN: when the counter reaches TIMEOUT_CYCLES without MemAck, MemTimeout=1 for that cycle, treated as MemAck (REQ-027), next RUN.
REQ-035 Without PAUSE_CTRL_TIMEOUT_EN: MemTimeout tied 0, port still present, MEM_WAIT unbounded, no counter logic.

Verification
REQ-036 ExMemRead=1, ExWriteIdx=3, IdUseRs1=1, IdRs1Idx=3 -> one cycle PauseIf=PauseId=BubbleEx=1, PauseEx=0; StallCount 0->1.
REQ-037 MemReq=1, MemAck low 4 cycles then high -> PauseIf/Id/Ex=1 for 5 cycles incl. entry cycle, 0 on ack cycle; StallCount=5.
REQ-038 BranchTaken=1 in cycle 2 of a 4-cycle memory wait -> no flush during wait; FlushId=BubbleEx=1 on MemAck cycle only.
REQ-039 BranchTaken=1 with simultaneous LU in RUN -> FlushId=BubbleEx=1, PauseIf=PauseId=0.
REQ-040 Rst pulsed low in MEM_WAIT -> all outputs 0 asynchronously, StallCount 0, RUN after release; with PAUSE_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8, MemAck never -> MemTimeout pulse at wait cycle 8, pauses drop same cycle.
